sr_cmd_sequencer: RTL
=====================

Name: sr_cmd_sequencer

Overview:
Upstream driver for the sr_flipflop stage. Accepts set/clear requests, arbitrates them, and emits a clean 2-bit sr command. The command is held for a programmable number of cycles, followed by a 00 guard gap. The block never emits the forbidden 11 code, and it counts conflicting requests.

Parameters:
HOLD_CYCLES, 2, cycles sr is driven with the active code (minimum 1)
GAP_CYCLES, 1, cycles of sr=00 after each command before the next is accepted (minimum 0)
CNT_W, 4, width of the conflict counter

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous active-high reset
set_req  input  1  request to set the downstream flop (level, sampled when req_ready=1)
clr_req  input  1  request to clear the downstream flop (level, sampled when req_ready=1)
q_fb  input  1  q fed back from the downstream flop (used only with the optional feature)
req_ready  output  1  1 only in IDLE; a request is accepted on an edge where req_ready=1
sr  output  2  registered command to the flop: 10=set, 01=clear, 00=hold
busy  output  1  1 in DRIVE or GAP
cmd_done  output  1  one-cycle pulse on the cycle the FSM returns to IDLE after a command
conflict_cnt  output  CNT_W  saturating count of simultaneous set+clr requests
rb_err  output  1  sticky readback error (optional feature)

Behaviour:
- Reset: clk is the clock; rst is synchronous and active-high.
  - Outputs after reset: state=IDLE, sr=00, req_ready=1, busy=0, cmd_done=0, conflict_cnt=0, rb_err=0.
  - All internal counters and pending flags are cleared.
- FSM states: IDLE, DRIVE, GAP.
- IDLE, edge with exactly one of set_req/clr_req high:
  - Latch the direction.
  - Load the hold counter with HOLD_CYCLES-1.
  - Go to DRIVE; sr becomes 10 or 01 in the next cycle (latency 1 clock from the accepting edge).
- IDLE, edge with both set_req and clr_req high:
  - Request dropped; stay in IDLE; sr stays 00.
  - conflict_cnt increments, saturating at 2^CNT_W-1 with no wrap.
- IDLE, edge with neither request high: no change.
- DRIVE:
  - sr holds the code for exactly HOLD_CYCLES cycles.
  - When the counter reaches 0: go to GAP with counter GAP_CYCLES-1 if GAP_CYCLES>0, otherwise straight to IDLE.
- GAP: sr=00 for exactly GAP_CYCLES cycles, then IDLE.
- cmd_done is asserted during the first IDLE cycle after DRIVE or GAP.
- Requests while busy are ignored, not queued. Requests held high are re-accepted in IDLE.
- sr is never 11 in any state, including the cycle after reset.
- rst mid-DRIVE or mid-GAP: abort to IDLE, sr=00 on the next cycle. No cmd_done is produced. The downstream flop keeps whatever state it last latched.
- Back-to-back, with requests held continuously: command period = HOLD_CYCLES+GAP_CYCLES+1 cycles (the IDLE cycle included).

Optional Feature:
Macro SR_READBACK_CHECK_EN.
- Defined:
  - A check is armed when DRIVE exits.
  - On the next clock edge after DRIVE exits, in GAP or IDLE, q_fb is compared to the expected value: 1 for set, 0 for clear.
  - A mismatch sets rb_err; it stays high until rst.
- Not defined: rb_err is tied to 0, q_fb is unused, and no check logic is synthesised.

Test Plan:
1. rst=1 for 2 cycles, then release with no requests -> sr=00, req_ready=1, busy=0, conflict_cnt=0.
2. Defaults (HOLD=2, GAP=1): set_req pulsed 1 cycle at edge T -> sr=10 during cycles T+1 and T+2; sr=00 at T+3 with busy=1; cmd_done=1 and req_ready=1 at T+4.
3. Same as scenario 2 with clr_req -> sr=01 for 2 cycles. When driving the sr_flipflop instance, q goes 1 then 0 across scenarios 2 and 3; rb_err stays 0 with SR_READBACK_CHECK_EN defined.
4. set_req=clr_req=1 for 20 cycles in IDLE, CNT_W=4 -> sr stays 00 throughout, conflict_cnt saturates at 15.
5. set_req asserted, then rst pulsed during the second DRIVE cycle -> sr=00 on the next cycle, state IDLE, cmd_done never pulses.
6. With SR_READBACK_CHECK_EN defined and q_fb forced to 0 during a set command -> rb_err=1 one cycle after DRIVE ends and stays 1 until rst.

Source files
------------

// File: rtl/sr_cmd_if.sv
// sr_cmd_if: request/command bundle between a requester and sr_cmd_sequencer.
// master drives requests and q feedback; slave returns the sr command and status.
interface sr_cmd_if #(
  parameter int CNT_W = 4
);
  logic             set_req;
  logic             clr_req;
  logic             q_fb;
  logic             req_ready;
  logic [1:0]       sr;
  logic             busy;
  logic             cmd_done;
  logic [CNT_W-1:0] conflict_cnt;
  logic             rb_err;

  modport master (
    output set_req, clr_req, q_fb,
    input  req_ready, sr, busy, cmd_done, conflict_cnt, rb_err
  );

  modport slave (
    input  set_req, clr_req, q_fb,
    output req_ready, sr, busy, cmd_done, conflict_cnt, rb_err
  );
endinterface

// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer: arbitrates set/clr requests into a held sr command plus guard gap.
// Optional readback check of q_fb enabled by SR_READBACK_CHECK_EN.
module sr_cmd_sequencer #(
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 4
) (
  input logic    clk,
  input logic    rst,
  sr_cmd_if.slave bus
);
  localparam int MX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = (MX > 1) ? $clog2(MX) : 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  =
    (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP
  } st_t;

  st_t             st, nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            dir, dir_nxt;
  logic [1:0]      sr_q;
  logic            done_q;
  logic [CNT_W-1:0] cfl;
  logic            both;

  assign both = bus.set_req & bus.clr_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= S_IDLE;
      cnt    <= '0;
      dir    <= 1'b0;
      sr_q   <= 2'b00;
      done_q <= 1'b0;
      cfl    <= '0;
    end else begin
      st     <= nxt;
      cnt    <= cnt_nxt;
      dir    <= dir_nxt;
      sr_q   <= (nxt == S_DRIVE) ? (dir_nxt ? 2'b10 : 2'b01) : 2'b00;
      done_q <= (st != S_IDLE) && (nxt == S_IDLE);
      if (st == S_IDLE && both && cfl != '1)
        cfl <= cfl + 1'b1;
    end
  end

  always_comb begin
    nxt     = st;
    cnt_nxt = cnt;
    dir_nxt = dir;
    unique case (st)
      S_IDLE: begin
        if (bus.set_req ^ bus.clr_req) begin
          nxt     = S_DRIVE;
          cnt_nxt = HOLD_LD;
          dir_nxt = bus.set_req;
        end
      end
      S_DRIVE: begin
        if (cnt == '0) begin
          if (GAP_CYCLES > 0) begin
            nxt     = S_GAP;
            cnt_nxt = GAP_LD;
          end else begin
            nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == '0) nxt = S_IDLE;
        else cnt_nxt = cnt - 1'b1;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready    = (st == S_IDLE);
    bus.busy         = (st != S_IDLE);
    bus.sr           = sr_q;
    bus.cmd_done     = done_q;
    bus.conflict_cnt = cfl;
  end

`ifdef SR_READBACK_CHECK_EN
  logic arm, exp_q, err;

  // Check fires one edge after DRIVE exits, giving the flop a cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      arm   <= 1'b0;
      exp_q <= 1'b0;
      err   <= 1'b0;
    end else begin
      arm   <= (st == S_DRIVE) && (nxt != S_DRIVE);
      exp_q <= dir;
      if (arm && bus.q_fb != exp_q)
        err <= 1'b1;
    end
  end

  assign bus.rb_err = err;
`else
  logic unused_q_fb;
  assign unused_q_fb = bus.q_fb;
  assign bus.rb_err  = 1'b0;
`endif

endmodule
